l2_mshr_mt_entry: RTL and testbench

// - One L2 MSHR entry with multi-target merging. Successor of the single-request MSHR.
// - Holds one missing line and issues one refill GET on channel A.
// - Absorbs up to MAX_TGT requests to the same line; PUT data is word-masked into the line and

---
 rtl/l2_mshr_mt_entry_pkg.sv | 29 ++
 rtl/l2_mshr_tgt_fifo.sv | 61 ++++++
 rtl/l2_mshr_mt_entry.sv | 198 +++++++++++++++++++
 tb/tb_l2_mshr_mt_entry.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_mshr_mt_entry_pkg.sv
// l2_mshr_mt_entry_pkg
// Shared field widths, TileLink-style opcodes and MSHR state encodings used by
// the multi-target MSHR entry and its target FIFO.
package l2_mshr_mt_entry_pkg;

    localparam int SET_BITS    = 6;
    localparam int TAG_BITS    = 20;
    localparam int WAY_BITS    = 2;
    localparam int OFFSET_BITS = 4;
    localparam int SOURCE_BITS = 4;
    localparam int OP_BITS     = 3;

    localparam logic [OP_BITS-1:0] OP_PUTFULL    = 3'd0;
    localparam logic [OP_BITS-1:0] OP_PUTPARTIAL = 3'd1;
    localparam logic [OP_BITS-1:0] OP_GET        = 3'd4;

    typedef enum logic [2:0] {
        MSHR_ST_IDLE   = 3'd0,
        MSHR_ST_REQ    = 3'd1,
        MSHR_ST_WAIT_D = 3'd2,
        MSHR_ST_DIR    = 3'd3,
        MSHR_ST_REPLAY = 3'd4
    } mshr_state_e;

    function automatic logic is_put(input logic [OP_BITS-1:0] op);
        return (op == OP_PUTFULL) || (op == OP_PUTPARTIAL);
    endfunction

endpackage

// File: rtl/l2_mshr_tgt_fifo.sv
// l2_mshr_tgt_fifo
// Target FIFO of one MSHR entry; holds {op, src, off} of every request merged
// into the line, in arrival order.
// Ports: clk, rst_n (async, active-low), push/din, pop/dout (head),
//        count (exact occupancy), empty, full.
module l2_mshr_tgt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/l2_mshr_mt_entry.sv
// l2_mshr_mt_entry
// One L2 MSHR entry with multi-target merging: issues one refill GET, absorbs
// same-line requests (PUT words masked into the line, overriding refill data),
// writes the directory, then replays every target in arrival order.
// Ports: alloc_* (primary miss), lookup_*/match_o (scheduler probe),
//        merge_* (secondary targets), a_* (refill GET), hold_i, d_* (refill data),
//        mixed_i (skip dir write), dir_* (directory update), resp_* (replay),
//        busy_o, tgt_cnt_o.
//
// state  | meaning
// IDLE   | free, accepting an allocation
// REQ    | refill GET presented on channel A
// WAIT_D | waiting for the refill data beat
// DIR    | directory update (skipped when mixed_r)
// REPLAY | presenting held targets on the response port
module l2_mshr_mt_entry
    import l2_mshr_mt_entry_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int WORD_W  = 32,
    parameter int MAX_TGT = 4,
    parameter int SET_W   = SET_BITS,
    parameter int TAG_W   = TAG_BITS,
    parameter int WAY_W   = WAY_BITS,
    parameter int OFF_W   = OFFSET_BITS,
    parameter int SRC_W   = SOURCE_BITS,
    parameter int OP_W    = OP_BITS,
    localparam int MASK_W = DATA_W / WORD_W,
    localparam int CNT_W  = $clog2(MAX_TGT + 1),
    localparam int TGT_W  = OP_W + SRC_W + OFF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid_i,
    output logic              alloc_ready_o,
    input  logic [SET_W-1:0]  alloc_set_i,
    input  logic [TAG_W-1:0]  alloc_tag_i,
    input  logic [WAY_W-1:0]  alloc_way_i,
    input  logic [OP_W-1:0]   alloc_op_i,
    input  logic [SRC_W-1:0]  alloc_src_i,
    input  logic [OFF_W-1:0]  alloc_off_i,
    input  logic [DATA_W-1:0] alloc_data_i,
    input  logic [MASK_W-1:0] alloc_mask_i,
    output logic              busy_o,
    output logic              match_o,
    input  logic [SET_W-1:0]  lookup_set_i,
    input  logic [TAG_W-1:0]  lookup_tag_i,
    input  logic              merge_valid_i,
    output logic              merge_ready_o,
    input  logic [OP_W-1:0]   merge_op_i,
    input  logic [SRC_W-1:0]  merge_src_i,
    input  logic [OFF_W-1:0]  merge_off_i,
    input  logic [DATA_W-1:0] merge_data_i,
    input  logic [MASK_W-1:0] merge_mask_i,
    output logic              a_valid_o,
    input  logic              a_ready_i,
    output logic [SET_W-1:0]  a_set_o,
    output logic [TAG_W-1:0]  a_tag_o,
    output logic [OP_W-1:0]   a_op_o,
    output logic [MASK_W-1:0] a_mask_o,
    input  logic              hold_i,
    input  logic              d_valid_i,
    input  logic [DATA_W-1:0] d_data_i,
    input  logic              mixed_i,
    output logic              dir_valid_o,
    input  logic              dir_ready_i,
    output logic [SET_W-1:0]  dir_set_o,
    output logic [TAG_W-1:0]  dir_tag_o,
    output logic [WAY_W-1:0]  dir_way_o,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [OP_W-1:0]   resp_op_o,
    output logic [SRC_W-1:0]  resp_src_o,
    output logic [OFF_W-1:0]  resp_off_o,
    output logic [DATA_W-1:0] resp_data_o,
    output logic [CNT_W-1:0]  tgt_cnt_o
);

    mshr_state_e       state, state_next;
    logic [SET_W-1:0]  set_r;
    logic [TAG_W-1:0]  tag_r;
    logic [WAY_W-1:0]  way_r;
    logic [DATA_W-1:0] line_data, line_next, refill_base;
    logic [MASK_W-1:0] dirty_mask, dirty_next;
    logic              mixed_r;

    logic              alloc_fire, merge_fire, merge_put, refill, pop;
    logic              fifo_empty, fifo_full;
    logic [TGT_W-1:0]  fifo_din, fifo_head;

    function automatic logic [DATA_W-1:0] wmask(input logic [MASK_W-1:0] m);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < MASK_W; i++) r[i*WORD_W +: WORD_W] = {WORD_W{m[i]}};
        return r;
    endfunction

    assign alloc_ready_o = (state == MSHR_ST_IDLE);
    assign busy_o        = (state != MSHR_ST_IDLE);
    assign match_o       = busy_o && (set_r == lookup_set_i) && (tag_r == lookup_tag_i);
    assign merge_ready_o = ((state == MSHR_ST_REQ) || (state == MSHR_ST_WAIT_D)) && !fifo_full;

    assign alloc_fire = alloc_valid_i && alloc_ready_o;
    assign merge_fire = merge_valid_i && merge_ready_o;
    assign merge_put  = merge_fire && is_put(merge_op_i);
    assign refill     = (state == MSHR_ST_WAIT_D) && d_valid_i;
    assign pop        = resp_valid_o && resp_ready_i;

    assign a_set_o     = set_r;
    assign a_tag_o     = tag_r;
    assign a_op_o      = OP_GET;
    assign a_mask_o    = '1;
    assign dir_set_o   = set_r;
    assign dir_tag_o   = tag_r;
    assign dir_way_o   = way_r;
    assign resp_data_o = line_data;
    assign {resp_op_o, resp_src_o, resp_off_o} = fifo_head;

    assign fifo_din = alloc_fire ? {alloc_op_i, alloc_src_i, alloc_off_i}
                                 : {merge_op_i, merge_src_i, merge_off_i};

    // A PUT merging in the same cycle as the refill beat already counts as
    // dirty for the blend, then its own words are laid over the result.
    always_comb begin
        dirty_next  = dirty_mask | (merge_put ? merge_mask_i : '0);
        refill_base = refill ? ((d_data_i & ~wmask(dirty_next)) | (line_data & wmask(dirty_next)))
                             : line_data;
        line_next   = merge_put ? ((refill_base & ~wmask(merge_mask_i)) |
                                   (merge_data_i & wmask(merge_mask_i)))
                                : refill_base;
    end

    always_comb begin
        state_next   = state;
        a_valid_o    = 1'b0;
        dir_valid_o  = 1'b0;
        resp_valid_o = 1'b0;
        case (state)
            MSHR_ST_IDLE:   if (alloc_valid_i) state_next = MSHR_ST_REQ;
            MSHR_ST_REQ: begin
                a_valid_o = !hold_i;
                if (!hold_i && a_ready_i) state_next = MSHR_ST_WAIT_D;
            end
            MSHR_ST_WAIT_D: if (d_valid_i) state_next = MSHR_ST_DIR;
            MSHR_ST_DIR: begin
                dir_valid_o = !mixed_r;
                if (mixed_r || dir_ready_i) state_next = MSHR_ST_REPLAY;
            end
            MSHR_ST_REPLAY: begin
                resp_valid_o = !fifo_empty;
                if (fifo_empty || ((tgt_cnt_o == CNT_W'(1)) && resp_ready_i))
                    state_next = MSHR_ST_IDLE;
            end
            default:        state_next = MSHR_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MSHR_ST_IDLE;
            set_r      <= '0;
            tag_r      <= '0;
            way_r      <= '0;
            line_data  <= '0;
            dirty_mask <= '0;
            mixed_r    <= 1'b0;
        end else begin
            state <= state_next;
            if (alloc_fire) begin
                set_r      <= alloc_set_i;
                tag_r      <= alloc_tag_i;
                way_r      <= alloc_way_i;
                line_data  <= alloc_data_i & wmask(alloc_mask_i);
                dirty_mask <= is_put(alloc_op_i) ? alloc_mask_i : '0;
                mixed_r    <= 1'b0;
            end else begin
                line_data  <= line_next;
                dirty_mask <= dirty_next;
                if (busy_o && mixed_i) mixed_r <= 1'b1;
            end
        end
    end

    l2_mshr_tgt_fifo #(
        .DEPTH (MAX_TGT),
        .WIDTH (TGT_W)
    ) u_tgt_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (alloc_fire || merge_fire),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_head),
        .count (tgt_cnt_o),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_l2_mshr_mt_entry.sv
// tb_l2_mshr_mt_entry
// Directed bench for l2_mshr_mt_entry with default parameters.
module tb_l2_mshr_mt_entry;
    import l2_mshr_mt_entry_pkg::*;

    logic                   clk, rst_n;
    logic                   alloc_valid, alloc_ready;
    logic [SET_BITS-1:0]    alloc_set;
    logic [TAG_BITS-1:0]    alloc_tag;
    logic [WAY_BITS-1:0]    alloc_way;
    logic [OP_BITS-1:0]     alloc_op;
    logic [SOURCE_BITS-1:0] alloc_src;
    logic [OFFSET_BITS-1:0] alloc_off;
    logic [127:0]           alloc_data;
    logic [3:0]             alloc_mask;
    logic                   busy, match;
    logic [SET_BITS-1:0]    lookup_set;
    logic [TAG_BITS-1:0]    lookup_tag;
    logic                   merge_valid, merge_ready;
    logic [OP_BITS-1:0]     merge_op;
    logic [SOURCE_BITS-1:0] merge_src;
    logic [OFFSET_BITS-1:0] merge_off;
    logic [127:0]           merge_data;
    logic [3:0]             merge_mask;
    logic                   a_valid, a_ready;
    logic [SET_BITS-1:0]    a_set;
    logic [TAG_BITS-1:0]    a_tag;
    logic [OP_BITS-1:0]     a_op;
    logic [3:0]             a_mask;
    logic                   hold, d_valid, mixed;
    logic [127:0]           d_data;
    logic                   dir_valid, dir_ready;
    logic [SET_BITS-1:0]    dir_set;
    logic [TAG_BITS-1:0]    dir_tag;
    logic [WAY_BITS-1:0]    dir_way;
    logic                   resp_valid, resp_ready;
    logic [OP_BITS-1:0]     resp_op;
    logic [SOURCE_BITS-1:0] resp_src;
    logic [OFFSET_BITS-1:0] resp_off;
    logic [127:0]           resp_data;
    logic [2:0]             tgt_cnt;

    int n_asserts = 0;
    int n_fail    = 0;

    l2_mshr_mt_entry dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready),
        .alloc_set_i(alloc_set), .alloc_tag_i(alloc_tag), .alloc_way_i(alloc_way),
        .alloc_op_i(alloc_op), .alloc_src_i(alloc_src), .alloc_off_i(alloc_off),
        .alloc_data_i(alloc_data), .alloc_mask_i(alloc_mask),
        .busy_o(busy), .match_o(match),
        .lookup_set_i(lookup_set), .lookup_tag_i(lookup_tag),
        .merge_valid_i(merge_valid), .merge_ready_o(merge_ready),
        .merge_op_i(merge_op), .merge_src_i(merge_src), .merge_off_i(merge_off),
        .merge_data_i(merge_data), .merge_mask_i(merge_mask),
        .a_valid_o(a_valid), .a_ready_i(a_ready), .a_set_o(a_set), .a_tag_o(a_tag),
        .a_op_o(a_op), .a_mask_o(a_mask), .hold_i(hold),
        .d_valid_i(d_valid), .d_data_i(d_data), .mixed_i(mixed),
        .dir_valid_o(dir_valid), .dir_ready_i(dir_ready),
        .dir_set_o(dir_set), .dir_tag_o(dir_tag), .dir_way_o(dir_way),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_op_o(resp_op), .resp_src_o(resp_src), .resp_off_o(resp_off),
        .resp_data_o(resp_data), .tgt_cnt_o(tgt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic ok);
        n_asserts++;
        if (ok !== 1'b1) begin
            n_fail++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic [OP_BITS-1:0] op, input logic [SOURCE_BITS-1:0] src,
                            input logic [127:0] data, input logic [3:0] mask);
        alloc_valid = 1'b1;
        alloc_op    = op;
        alloc_src   = src;
        alloc_off   = src;
        alloc_data  = data;
        alloc_mask  = mask;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_merge(input logic [OP_BITS-1:0] op, input logic [SOURCE_BITS-1:0] src,
                            input logic [127:0] data, input logic [3:0] mask);
        merge_valid = 1'b1;
        merge_op    = op;
        merge_src   = src;
        merge_off   = src;
        merge_data  = data;
        merge_mask  = mask;
        tick();
        merge_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        alloc_valid = 0; alloc_set = 6'd5; alloc_tag = 20'h12345; alloc_way = 2'd2;
        alloc_op = OP_GET; alloc_src = 0; alloc_off = 0; alloc_data = '0; alloc_mask = '0;
        lookup_set = 6'd5; lookup_tag = 20'h12345;
        merge_valid = 0; merge_op = OP_GET; merge_src = 0; merge_off = 0;
        merge_data = '0; merge_mask = '0;
        a_ready = 0; hold = 0; d_valid = 0; d_data = '0; mixed = 0;
        dir_ready = 0; resp_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy === 1'b0);
        check("rst_alloc_ready", alloc_ready === 1'b1);
        check("rst_valids", {a_valid, dir_valid, resp_valid, merge_ready} === 4'b0000);
        check("rst_tgt_cnt", tgt_cnt === 3'd0);
        check("rst_match", match === 1'b0);
        rst_n = 1'b1;
        tick();

        // Plain GET miss
        do_alloc(OP_GET, 4'd3, '0, 4'b0000);
        check("get_a_valid", a_valid === 1'b1);
        check("get_a_addr", {a_set, a_tag} === {6'd5, 20'h12345});
        check("get_a_op_mask", {a_op, a_mask} === {OP_GET, 4'hF});
        check("get_busy_ready", {busy, alloc_ready} === 2'b10);
        check("get_tgt_cnt", tgt_cnt === 3'd1);
        check("get_match_hit", match === 1'b1);
        lookup_tag = 20'h12346;
        #1;
        check("get_match_miss", match === 1'b0);
        lookup_tag = 20'h12345;
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        check("get_wait_a_low", a_valid === 1'b0);
        d_valid = 1'b1; d_data = {16{8'hA5}};
        tick();
        d_valid = 1'b0;
        check("get_dir_valid", dir_valid === 1'b1);
        check("get_dir_fields", {dir_way, dir_set, dir_tag} === {2'd2, 6'd5, 20'h12345});
        check("get_no_resp_in_dir", resp_valid === 1'b0);
        dir_ready = 1'b1;
        tick();
        dir_ready = 1'b0;
        check("get_resp_valid", resp_valid === 1'b1);
        check("get_resp_src", resp_src === 4'd3);
        check("get_resp_data", resp_data === {16{8'hA5}});
        check("get_merge_rej_replay", merge_ready === 1'b0);
        resp_ready = 1'b1;
        #1;
        check("get_no_realloc_last_pop", alloc_ready === 1'b0);
        tick();
        resp_ready = 1'b0;
        check("get_idle", {busy, alloc_ready, resp_valid} === 3'b010);

        // PUT merge overrides refill word 1
        do_alloc(OP_GET, 4'd1, '0, 4'b0000);
        check("put_merge_ready", merge_ready === 1'b1);
        do_merge(OP_PUTPARTIAL, 4'd2, 128'h00000000_00000000_11111111_00000000, 4'b0010);
        check("put_tgt_cnt", tgt_cnt === 3'd2);
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        d_valid = 1'b1; d_data = '1;
        tick();
        d_valid = 1'b0;
        dir_ready = 1'b1;
        tick();
        dir_ready = 1'b0;
        check("put_resp_data", resp_data === 128'hFFFFFFFF_FFFFFFFF_11111111_FFFFFFFF);
        check("put_resp0_src", resp_src === 4'd1);
        resp_ready = 1'b1;
        tick();
        check("put_resp1_valid", resp_valid === 1'b1);
        check("put_resp1", {resp_op, resp_src} === {OP_PUTPARTIAL, 4'd2});
        tick();
        resp_ready = 1'b0;
        check("put_idle", busy === 1'b0);

        // Full target FIFO, with hold on channel A
        hold = 1'b1;
        do_alloc(OP_GET, 4'd4, '0, 4'b0000);
        check("hold_a_low", a_valid === 1'b0);
        a_ready = 1'b1;
        for (int i = 0; i < 3; i++) do_merge(OP_GET, 4'(5 + i), '0, 4'b0000);
        check("full_tgt_cnt", tgt_cnt === 3'd4);
        check("full_merge_ready", merge_ready === 1'b0);
        check("hold_still_req", a_valid === 1'b0);
        do_merge(OP_GET, 4'd8, '0, 4'b0000);
        check("full_5th_rejected", tgt_cnt === 3'd4);
        hold = 1'b0;
        #1;
        check("hold_released", a_valid === 1'b1);
        tick();
        a_ready = 1'b0;
        check("full_wait_d", {a_valid, busy} === 2'b01);
        d_valid = 1'b1; d_data = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        tick();
        d_valid = 1'b0;
        dir_ready = 1'b1;
        tick();
        dir_ready = 1'b0;
        check("full_resp_data", resp_data === 128'h01234567_89ABCDEF_FEDCBA98_76543210);
        for (int k = 0; k < 4; k++) begin
            resp_ready = 1'b0;
            tick();
            check("full_resp_valid", resp_valid === 1'b1);
            check("full_resp_src", resp_src === 4'(4 + k));
            resp_ready = 1'b1;
            tick();
        end
        resp_ready = 1'b0;
        check("full_idle", {busy, tgt_cnt} === 4'b0000);

        // Same-cycle merge PUT and refill, alloc as PUT
        do_alloc(OP_PUTPARTIAL, 4'd9, 128'h00000000_22222222_00000000_00000000, 4'b0100);
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        d_valid = 1'b1; d_data = {4{32'h33333333}};
        merge_valid = 1'b1; merge_op = OP_PUTPARTIAL; merge_src = 4'd10; merge_off = 4'd10;
        merge_data = 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF; merge_mask = 4'b0001;
        tick();
        d_valid = 1'b0; merge_valid = 1'b0;
        check("same_tgt_cnt", tgt_cnt === 3'd2);
        check("same_dir_valid", dir_valid === 1'b1);
        dir_ready = 1'b1;
        tick();
        dir_ready = 1'b0;
        check("same_resp_data", resp_data === 128'h33333333_22222222_33333333_DEADBEEF);
        check("same_resp0", {resp_op, resp_src} === {OP_PUTPARTIAL, 4'd9});
        resp_ready = 1'b1;
        tick();
        tick();
        resp_ready = 1'b0;
        check("same_idle", busy === 1'b0);

        // mixed_i skips the directory write
        do_alloc(OP_GET, 4'd11, '0, 4'b0000);
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        mixed = 1'b1;
        tick();
        mixed = 1'b0;
        d_valid = 1'b1; d_data = {4{32'hCAFEF00D}};
        dir_ready = 1'b1;
        tick();
        d_valid = 1'b0;
        check("mixed_in_dir", {busy, dir_valid, resp_valid} === 3'b100);
        tick();
        dir_ready = 1'b0;
        check("mixed_replay", {dir_valid, resp_valid} === 2'b01);
        check("mixed_resp_src", resp_src === 4'd11);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("mixed_idle", busy === 1'b0);

        // Reset in REPLAY with two targets left
        do_alloc(OP_GET, 4'd1, '0, 4'b0000);
        do_merge(OP_GET, 4'd2, '0, 4'b0000);
        do_merge(OP_GET, 4'd3, '0, 4'b0000);
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
        dir_ready = 1'b1;
        tick();
        dir_ready = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("rreplay_left", {resp_valid, tgt_cnt} === {1'b1, 3'd2});
        rst_n = 1'b0;
        #1;
        check("rreplay_busy", busy === 1'b0);
        check("rreplay_alloc_ready", alloc_ready === 1'b1);
        check("rreplay_tgt_cnt", tgt_cnt === 3'd0);
        check("rreplay_no_resp", resp_valid === 1'b0);
        tick();
        rst_n = 1'b1;
        resp_ready = 1'b1;
        tick();
        check("rreplay_after", {busy, resp_valid, tgt_cnt} === 5'b00000);
        resp_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
